// File: rtl/decimal_entry_to_val_pkg.sv
// Purpose: shared types and constants for the decimal keypad entry converter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, entry width/range constants and the
// multiply-by-ten accumulate step used during conversion.
package decimal_entry_to_val_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // no digits held
        ST_ENTRY   = 2'd1,  // one to three digits held
        ST_CONVERT = 2'd2,  // three-cycle BCD to binary accumulate
        ST_CHECK   = 2'd3   // one-cycle range check and result update
    } state_e;

    localparam int DIGITS      = 3;
    localparam int MAX_POS     = 127;
    localparam int MAX_NEG_MAG = 128;
    localparam int ACC_W       = 10;   // holds up to 999

    // One Horner step: acc*10 + digit. With at most three digits the
    // result never exceeds 999, so ACC_W bits cannot overflow.
    function automatic logic [ACC_W-1:0] acc_step(
        input logic [ACC_W-1:0] acc,
        input logic [3:0]       dig
    );
        acc_step = (acc * ACC_W'(10)) + {{(ACC_W-4){1'b0}}, dig};
    endfunction

endpackage

// File: rtl/decimal_entry_to_val.sv
// Purpose: collect up to three keyed decimal digits plus a sign and convert to an 8-bit two's complement value.
// Latency: enter sampled at edge k -> val/val_valid or range_err visible after edge k+4.
// Backpressure: none; strobes arriving while busy are dropped (clear still aborts).
//
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   digit_valid, digit     - keyed digit strobe and value (0-9 legal, 10-15 ignored)
//   neg_toggle             - flip pending sign
//   enter, clear           - start conversion / discard entry or abort conversion
//   val, val_valid         - last accepted value and its one-cycle update pulse
//   range_err              - one-cycle pulse when the entry does not fit in 8 bits
//   busy                   - high while converting or checking
//   entry_hun/ten/one, entry_neg - pending digits and sign for display echo
module decimal_entry_to_val
    import decimal_entry_to_val_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       neg_toggle,
    input  logic       enter,
    input  logic       clear,
    output logic [7:0] val,
    output logic       val_valid,
    output logic       range_err,
    output logic       busy,
    output logic [3:0] entry_hun,
    output logic [3:0] entry_ten,
    output logic [3:0] entry_one,
    output logic       entry_neg
);

    state_e             state_q, state_d;
    logic [3:0]         hun_q, hun_d;
    logic [3:0]         ten_q, ten_d;
    logic [3:0]         one_q, one_d;
    logic               neg_q, neg_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [1:0]         step_q, step_d;
    logic [7:0]         val_q, val_d;
    logic               val_valid_q, val_valid_d;
    logic               range_err_q, range_err_d;

    logic               in_range;
    logic [7:0]         mag8;

    // Magnitude limit is asymmetric: -128 fits, +128 does not.
    assign in_range = neg_q ? (acc_q <= ACC_W'(MAX_NEG_MAG))
                            : (acc_q <= ACC_W'(MAX_POS));
    assign mag8     = acc_q[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hun_q       <= 4'd0;
            ten_q       <= 4'd0;
            one_q       <= 4'd0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            step_q      <= 2'd0;
            val_q       <= 8'h00;
            val_valid_q <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hun_q       <= hun_d;
            ten_q       <= ten_d;
            one_q       <= one_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
            val_q       <= val_d;
            val_valid_q <= val_valid_d;
            range_err_q <= range_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hun_d       = hun_q;
        ten_d       = ten_q;
        one_d       = one_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        step_d      = step_q;
        val_d       = val_q;
        val_valid_d = 1'b0;
        range_err_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                // Strobes are strictly prioritised; only the winner acts.
                if (clear) begin
                    hun_d   = 4'd0;
                    ten_d   = 4'd0;
                    one_d   = 4'd0;
                    neg_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (enter) begin
                    if (state_q == ST_ENTRY) begin
                        acc_d   = '0;
                        step_d  = 2'd0;
                        state_d = ST_CONVERT;
                    end
                end else if (digit_valid) begin
                    if (digit <= 4'd9) begin
                        hun_d   = ten_q;
                        ten_d   = one_q;
                        one_d   = digit;
                        state_d = ST_ENTRY;
                    end
                end else if (neg_toggle) begin
                    neg_d = ~neg_q;
                end
            end

            ST_CONVERT: begin
                if (clear) begin
                    hun_d   = 4'd0;
                    ten_d   = 4'd0;
                    one_d   = 4'd0;
                    neg_d   = 1'b0;
                    acc_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    // Most significant digit first: hun, ten, one.
                    case (step_q)
                        2'd0:    acc_d = acc_step(acc_q, hun_q);
                        2'd1:    acc_d = acc_step(acc_q, ten_q);
                        default: acc_d = acc_step(acc_q, one_q);
                    endcase
                    step_d = step_q + 2'd1;
                    if (step_q == 2'd2) begin
                        state_d = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                if (!clear) begin
                    if (in_range) begin
                        // For -128 the low byte is already 0x80; negating it is harmless.
                        val_d       = neg_q ? (~mag8 + 8'd1) : mag8;
                        val_valid_d = 1'b1;
                    end else begin
                        range_err_d = 1'b1;
                    end
                end
                hun_d   = 4'd0;
                ten_d   = 4'd0;
                one_d   = 4'd0;
                neg_d   = 1'b0;
                acc_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign val       = val_q;
    assign val_valid = val_valid_q;
    assign range_err = range_err_q;
    assign busy      = (state_q == ST_CONVERT) || (state_q == ST_CHECK);
    assign entry_hun = hun_q;
    assign entry_ten = ten_q;
    assign entry_one = one_q;
    assign entry_neg = neg_q;

endmodule

// File: tb/tb_decimal_entry_to_val.sv
// Purpose: self-checking bench for decimal_entry_to_val against a digit-queue reference model.
// Latency: model predicts result four edges after enter.
// Backpressure: n/a.
module tb_decimal_entry_to_val;

    logic       clk = 1'b0;
    logic       rst;
    logic       digit_valid;
    logic [3:0] digit;
    logic       neg_toggle;
    logic       enter;
    logic       clear;
    logic [7:0] val;
    logic       val_valid;
    logic       range_err;
    logic       busy;
    logic [3:0] entry_hun;
    logic [3:0] entry_ten;
    logic [3:0] entry_one;
    logic       entry_neg;

    decimal_entry_to_val dut (
        .clk         (clk),
        .rst         (rst),
        .digit_valid (digit_valid),
        .digit       (digit),
        .neg_toggle  (neg_toggle),
        .enter       (enter),
        .clear       (clear),
        .val         (val),
        .val_valid   (val_valid),
        .range_err   (range_err),
        .busy        (busy),
        .entry_hun   (entry_hun),
        .entry_ten   (entry_ten),
        .entry_one   (entry_one),
        .entry_neg   (entry_neg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the pending entry is a queue of keyed digits (last three kept),
    // a sign flag, and a countdown of edges until the pending conversion resolves.
    int q[$];
    bit m_neg;
    int m_busy;
    int m_val;
    bit m_vv;
    bit m_re;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int qdig(input int pos);  // pos 0=ones, 1=tens, 2=hundreds
        if (q.size() > pos) return q[q.size() - 1 - pos];
        return 0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_neg  = 0;
        m_busy = 0;
        m_val  = 0;
        m_vv   = 0;
        m_re   = 0;
    endtask

    task automatic model_step(input bit dv, input int d, input bit ng, input bit en, input bit cl);
        int mag;
        m_vv = 0;
        m_re = 0;
        if (m_busy > 0) begin
            if (cl) begin
                q.delete(); m_neg = 0; m_busy = 0;
            end else begin
                m_busy--;
                if (m_busy == 0) begin
                    mag = 100 * qdig(2) + 10 * qdig(1) + qdig(0);
                    if ((!m_neg && mag <= 127) || (m_neg && mag <= 128)) begin
                        m_val = m_neg ? (256 - mag) % 256 : mag;
                        m_vv  = 1;
                    end else begin
                        m_re = 1;
                    end
                    q.delete(); m_neg = 0;
                end
            end
        end else if (cl) begin
            q.delete(); m_neg = 0;
        end else if (en) begin
            if (q.size() > 0) m_busy = 4;
        end else if (dv) begin
            if (d < 10) begin
                q.push_back(d);
                if (q.size() > 3) void'(q.pop_front());
            end
        end else if (ng) begin
            m_neg = !m_neg;
        end
    endtask

    task automatic check_all();
        chk("val",       int'(val),       m_val);
        chk("val_valid", int'(val_valid), int'(m_vv));
        chk("range_err", int'(range_err), int'(m_re));
        chk("busy",      int'(busy),      int'(m_busy > 0));
        chk("entry_hun", int'(entry_hun), qdig(2));
        chk("entry_ten", int'(entry_ten), qdig(1));
        chk("entry_one", int'(entry_one), qdig(0));
        chk("entry_neg", int'(entry_neg), int'(m_neg));
        chk("pulse_excl", int'(val_valid & range_err), 0);
    endtask

    // Drive one cycle of strobes, advance the model on the edge, check 1 ns later.
    task automatic cyc(input bit dv, input int d, input bit ng, input bit en, input bit cl);
        digit_valid = dv;
        digit       = 4'(d);
        neg_toggle  = ng;
        enter       = en;
        clear       = cl;
        @(posedge clk);
        model_step(dv, d, ng, en, cl);
        #1;
        check_all();
        digit_valid = 0;
        neg_toggle  = 0;
        enter       = 0;
        clear       = 0;
    endtask

    task automatic key(input int d);
        cyc(1, d, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset pulse placed between edges; outputs must clear before the next edge.
    task automatic async_reset();
        #2 rst = 1;
        #1;
        model_reset();
        check_all();
        #1 rst = 0;
    endtask

    initial begin
        rst = 1; digit_valid = 0; digit = 0; neg_toggle = 0; enter = 0; clear = 0;
        #1;
        model_reset();
        check_all();
        #2 rst = 0;

        // 1,2,7 -> +127
        key(1); key(2); key(7); cyc(0, 0, 0, 1, 0); idle(5);
        // -128 accepted, then +128 rejected with val holding
        cyc(0, 0, 1, 0, 0); key(1); key(2); key(8); cyc(0, 0, 0, 1, 0); idle(5);
        key(1); key(2); key(8); cyc(0, 0, 0, 1, 0); idle(5);
        // oldest digit dropped, illegal digit ignored
        key(9); key(0); key(4); key(12); key(2); cyc(0, 0, 0, 1, 0); idle(5);
        // "-0"
        cyc(0, 0, 1, 0, 0); key(0); cyc(0, 0, 0, 1, 0); idle(5);
        // abort two cycles after enter; then enter and clear together
        key(5); key(5); cyc(0, 0, 0, 1, 0); idle(1); cyc(0, 0, 0, 0, 1); idle(5);
        key(5); cyc(0, 0, 0, 1, 1); idle(5);
        // async reset mid-entry, then enter with no digits
        key(3); cyc(0, 0, 1, 0, 0); async_reset(); cyc(0, 0, 0, 1, 0); idle(5);
        // async reset mid-conversion produces no pulse afterwards
        key(4); key(5); cyc(0, 0, 0, 1, 0); idle(1); async_reset(); idle(6);
        // strobes ignored while busy
        key(6); cyc(0, 0, 0, 1, 0); key(7); cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 1, 0); idle(4);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            int d;
            r = $urandom_range(0, 99);
            d = $urandom_range(0, 11);
            if (r < 40)      cyc(1, d, 0, 0, 0);
            else if (r < 50) cyc(0, 0, 1, 0, 0);
            else if (r < 62) cyc(0, 0, 0, 1, 0);
            else if (r < 65) cyc(0, 0, 0, 0, 1);
            else if (r < 67) cyc($urandom_range(0, 1), d, $urandom_range(0, 1), $urandom_range(0, 1), 1);
            else if (r < 70 && (q.size() > 0 || m_busy > 0)) cyc(1, d, 0, 1, 0);
            else if (r < 73) cyc(1, $urandom_range(0, 9), 1, 0, 0);
            else             cyc(0, 0, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
